// File: rtl/axis_uart_pkg.sv
// axis_uart_pkg: shared types and widths for the AXI-Stream UART transmit path
// Optional parity framing is selected by AXIS_UART_TX_PARITY_EN in the users of this package.
package axis_uart_pkg;
    localparam int UART_DATA_BITS = 8;
    localparam int AXIS_DATA_W    = 32;
    localparam int AXIS_KEEP_W    = 4;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte-level 8N1 framer with baud counter, FSM and LSB-first shifter
// Ports: clk, reset_n (async, active-low); byte_data/byte_valid/byte_last in, byte_ready out
// (combinational, high in IDLE or on the final stop-bit cycle so frames chain back-to-back);
// uart_tx serial line (registered, idle high); busy = FSM not IDLE; last_done one-cycle pulse.
// AXIS_UART_TX_PARITY_EN adds an even-parity bit between data and stop bits.
module uart_tx_serializer
    import axis_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [UART_DATA_BITS-1:0] byte_data,
    input  logic                      byte_valid,
    input  logic                      byte_last,
    output logic                      byte_ready,
    output logic                      uart_tx,
    output logic                      busy,
    output logic                      last_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] DATA_LAST = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
    tx_state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0] idx, idx_d;
    logic [UART_DATA_BITS-1:0] sh, sh_d;
    logic cur_last, cur_last_d, tx_d, done_d, tick;
`ifdef AXIS_UART_TX_PARITY_EN
    logic par, par_d;
`endif
    assign tick = cnt == '0;
    assign byte_ready = state == IDLE || (state == STOP && tick && idx == STOP_LAST);
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            cur_last  <= 1'b0;
            uart_tx   <= 1'b1;
            last_done <= 1'b0;
`ifdef AXIS_UART_TX_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            idx       <= idx_d;
            sh        <= sh_d;
            cur_last  <= cur_last_d;
            uart_tx   <= tx_d;
            last_done <= done_d;
`ifdef AXIS_UART_TX_PARITY_EN
            par       <= par_d;
`endif
        end
    end
    always_comb begin
        state_d    = state;
        cnt_d      = tick ? cnt : cnt - 1'b1;
        idx_d      = idx;
        sh_d       = sh;
        cur_last_d = cur_last;
        done_d     = 1'b0;
`ifdef AXIS_UART_TX_PARITY_EN
        par_d      = par;
`endif
        case (state)
            START: if (tick) begin
                state_d = DATA;
                cnt_d   = BAUD_MAX;
            end
            DATA: if (tick) begin
                cnt_d = BAUD_MAX;
                sh_d  = sh >> 1;
                idx_d = idx + 3'd1;
                if (idx == DATA_LAST) begin
                    idx_d = '0;
`ifdef AXIS_UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef AXIS_UART_TX_PARITY_EN
            PARITY: if (tick) begin
                state_d = STOP;
                cnt_d   = BAUD_MAX;
            end
`endif
            STOP: if (tick) begin
                cnt_d = BAUD_MAX;
                idx_d = idx + 3'd1;
                if (idx == STOP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    done_d  = cur_last;
                end
            end
            default: ;
        endcase
        // A pending byte overrides the return to IDLE so frames chain with no idle cycle.
        if (byte_valid && byte_ready) begin
            state_d    = START;
            cnt_d      = BAUD_MAX;
            idx_d      = '0;
            sh_d       = byte_data;
            cur_last_d = byte_last;
`ifdef AXIS_UART_TX_PARITY_EN
            par_d      = ^byte_data;
`endif
        end
`ifdef AXIS_UART_TX_PARITY_EN
        tx_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : state_d == PARITY ? par_d : 1'b1;
`else
        tx_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : 1'b1;
`endif
    end
endmodule

// File: rtl/axis_uart_tx.sv
// axis_uart_tx: AXI-Stream slave that sends each TKEEP-selected byte as a UART frame
// Ports: clk, reset_n (async, active-low); S_AXIS_TVALID/TREADY/TDATA[31:0]/TKEEP[3:0]/TLAST
// stream input (TREADY registered); uart_tx serial line idle high; busy = frame on line or
// word buffered; last_done one-cycle pulse when a TLAST word has fully gone out.
// AXIS_UART_TX_PARITY_EN enables even parity in the serializer.
module axis_uart_tx
    import axis_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   S_AXIS_TVALID,
    output logic                   S_AXIS_TREADY,
    input  logic [AXIS_DATA_W-1:0] S_AXIS_TDATA,
    input  logic [AXIS_KEEP_W-1:0] S_AXIS_TKEEP,
    input  logic                   S_AXIS_TLAST,
    output logic                   uart_tx,
    output logic                   busy,
    output logic                   last_done
);
    logic [AXIS_DATA_W-1:0] buf_data;
    logic [AXIS_KEEP_W-1:0] buf_keep, rem;
    logic [UART_DATA_BITS-1:0] byte_data;
    logic [1:0] sel;
    logic buf_last, buf_valid, zero_done, byte_valid, byte_ready, byte_last, ser_busy, ser_done;
    // buf_keep holds the bytes still to send; the lowest set bit picks the next one.
    assign sel        = buf_keep[0] ? 2'd0 : buf_keep[1] ? 2'd1 : buf_keep[2] ? 2'd2 : 2'd3;
    assign byte_data  = buf_data[{sel, 3'b000} +: UART_DATA_BITS];
    assign rem        = buf_keep & ~(AXIS_KEEP_W'(1) << sel);
    assign byte_valid = buf_valid && |buf_keep;
    assign byte_last  = buf_last && rem == '0;
    assign busy       = ser_busy || buf_valid;
    assign last_done  = ser_done || zero_done;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_data      <= '0;
            buf_keep      <= '0;
            buf_last      <= 1'b0;
            buf_valid     <= 1'b0;
            S_AXIS_TREADY <= 1'b0;
            zero_done     <= 1'b0;
        end else begin
            zero_done <= 1'b0;
            if (S_AXIS_TVALID && S_AXIS_TREADY) begin
                buf_data      <= S_AXIS_TDATA;
                buf_keep      <= S_AXIS_TKEEP;
                buf_last      <= S_AXIS_TLAST;
                buf_valid     <= 1'b1;
                S_AXIS_TREADY <= 1'b0;
            end else if (buf_valid && buf_keep == '0) begin
                buf_valid     <= 1'b0;
                S_AXIS_TREADY <= 1'b1;
                zero_done     <= buf_last;
            end else if (byte_valid && byte_ready) begin
                buf_keep <= rem;
                if (rem == '0) begin
                    buf_valid     <= 1'b0;
                    S_AXIS_TREADY <= 1'b1;
                end
            end else begin
                S_AXIS_TREADY <= !buf_valid;
            end
        end
    end
    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .STOP_BITS   (STOP_BITS)
    ) u_ser (
        .clk       (clk),
        .reset_n   (reset_n),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_last (byte_last),
        .byte_ready(byte_ready),
        .uart_tx   (uart_tx),
        .busy      (ser_busy),
        .last_done (ser_done)
    );
endmodule

// File: tb/tb_axis_uart_tx.sv
// tb_axis_uart_tx: directed self-checking bench for axis_uart_tx at 4 clocks per bit, 1 stop bit
module tb_axis_uart_tx;
    localparam int CPB = 4;
`ifdef AXIS_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    logic clk = 1'b0, reset_n = 1'b0, tvalid = 1'b0, tlast = 1'b0;
    logic [31:0] tdata = '0;
    logic [3:0] tkeep = '0;
    logic tready, uart_tx, busy, last_done;
    int n_vec = 0, n_bad = 0, ld_seen = 0;
    always #5 clk = ~clk;
    axis_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .S_AXIS_TVALID(tvalid),
        .S_AXIS_TREADY(tready),
        .S_AXIS_TDATA (tdata),
        .S_AXIS_TKEEP (tkeep),
        .S_AXIS_TLAST (tlast),
        .uart_tx      (uart_tx),
        .busy         (busy),
        .last_done    (last_done)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
        tvalid = 1'b1;
        tdata  = d;
        tkeep  = k;
        tlast  = l;
        for (int i = 0; i < 200 && !tready; i++) @(negedge clk);
        check("hs_ready", 64'(tready), 64'(1));
        @(negedge clk);
        tvalid = 1'b0;
    endtask
    task automatic expect_frame(input logic [7:0] b);
        logic [63:0] cap, exp;
        logic [NB-1:0] bits;
`ifdef AXIS_UART_TX_PARITY_EN
        bits = {1'b1, ^b, b, 1'b0};
`else
        bits = {1'b1, b, 1'b0};
`endif
        cap = '0;
        exp = '0;
        for (int k = 0; k < NB * CPB; k++) begin
            exp[k] = bits[k / CPB];
            cap[k] = uart_tx;
            if (last_done) ld_seen++;
            @(negedge clk);
        end
        check($sformatf("frame_%02h", b), cap, exp);
    endtask
    task automatic idle_watch(input int n);
        int lows;
        lows = 0;
        ld_seen = 0;
        for (int k = 0; k < n; k++) begin
            if (!uart_tx) lows++;
            if (last_done) ld_seen++;
            @(negedge clk);
        end
        check("idle_lows", 64'(lows), 64'(0));
        check("idle_ld", 64'(ld_seen), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));
    endtask
    task automatic reset_mid(input logic [7:0] b, input int n, input logic pre);
        send({24'h0, b}, 4'b0001, 1'b1);
        repeat (n + 1) @(negedge clk);
        check("pre_rst_tx", 64'(uart_tx), 64'(pre));
        check("pre_rst_busy", 64'(busy), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        check("rst_tx", 64'(uart_tx), 64'(1));
        check("rst_tready", 64'(tready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rel_tready", 64'(tready), 64'(1));
        idle_watch(50);
    endtask
    initial begin
        @(negedge clk);
        check("rst_line", 64'(uart_tx), 64'(1));
        check("rst_ready", 64'(tready), 64'(0));
        check("rst_busy0", 64'(busy), 64'(0));
        check("rst_ld", 64'(last_done), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_rel", 64'(tready), 64'(1));
        check("line_after_rel", 64'(uart_tx), 64'(1));
        send(32'h0000_0055, 4'b0001, 1'b1);
        check("lat_tx_hi", 64'(uart_tx), 64'(1));
        check("hs_tready_lo", 64'(tready), 64'(0));
        check("hs_busy", 64'(busy), 64'(1));
        @(negedge clk);
        ld_seen = 0;
        expect_frame(8'h55);
        check("ld_in_55", 64'(ld_seen), 64'(0));
        check("ld_55", 64'(last_done), 64'(1));
        check("busy_after_55", 64'(busy), 64'(0));
        @(negedge clk);
        check("ld_55_off", 64'(last_done), 64'(0));
        send(32'h4433_2211, 4'b1111, 1'b0);
        tvalid = 1'b1;
        tdata  = 32'h8877_6655;
        tkeep  = 4'b1111;
        tlast  = 1'b1;
        check("w2_wait", 64'(tready), 64'(0));
        @(negedge clk);
        ld_seen = 0;
        expect_frame(8'h11);
        expect_frame(8'h22);
        expect_frame(8'h33);
        check("tready_at_44", 64'(tready), 64'(1));
        fork
            expect_frame(8'h44);
            begin
                @(negedge clk);
                check("tready_hs2", 64'(tready), 64'(0));
                tvalid = 1'b0;
            end
        join
        expect_frame(8'h55);
        expect_frame(8'h66);
        expect_frame(8'h77);
        expect_frame(8'h88);
        check("ld_in_b2b", 64'(ld_seen), 64'(0));
        check("ld_88", 64'(last_done), 64'(1));
        check("busy_after_88", 64'(busy), 64'(0));
        send(32'hDDCC_BBAA, 4'b1010, 1'b1);
        @(negedge clk);
        ld_seen = 0;
        expect_frame(8'hBB);
        expect_frame(8'hDD);
        check("ld_in_sparse", 64'(ld_seen), 64'(0));
        check("ld_sparse", 64'(last_done), 64'(1));
        check("busy_sparse", 64'(busy), 64'(0));
        @(negedge clk);
        send(32'hDEAD_BEEF, 4'b0000, 1'b1);
        check("z_ld0", 64'(last_done), 64'(0));
        check("z_busy", 64'(busy), 64'(1));
        @(negedge clk);
        check("z_ld1", 64'(last_done), 64'(1));
        check("z_tready", 64'(tready), 64'(1));
        check("z_busy0", 64'(busy), 64'(0));
        check("z_line", 64'(uart_tx), 64'(1));
        @(negedge clk);
        idle_watch(20);
        send(32'h0000_0007, 4'b0001, 1'b1);
        @(negedge clk);
        ld_seen = 0;
        expect_frame(8'h07);
        check("ld_07", 64'(last_done), 64'(1));
        @(negedge clk);
        reset_mid(8'hFF, 10, 1'b1);
        reset_mid(8'h00, 2, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
